// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, frame bit positions and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    RELEASE,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [3:0] BIT_PARITY = 4'd9;
  localparam logic [3:0] BIT_STOP   = 4'd10;
  localparam logic [3:0] BIT_ACK    = 4'd11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_fall.sv
// Three-flop synchronizer for one raw PS/2 pin plus falling-edge detect.
module ps2_sync_fall (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [2:0] sync;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk) begin
    if (rst) sync <= 3'b111;
    else     sync <= {sync[1:0], pin};
  end

  assign level = sync[1];
  assign fall  = sync[2] & ~sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FIRST_TIMEOUT  = 750000,
  parameter int EDGE_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [19:0] INH_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] FIRST_LIM = 20'(FIRST_TIMEOUT);
  localparam logic [19:0] EDGE_LIM  = 20'(EDGE_TIMEOUT);

  logic       clk_s, clk_fall;
  logic       data_s, data_fall_unused;

  ps2_sync_fall u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_clk),
    .level (clk_s),
    .fall  (clk_fall)
  );

  ps2_sync_fall u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_data),
    .level (data_s),
    .fall  (data_fall_unused)
  );

  ps2_state_t  state;
  logic [19:0] cnt;
  logic [3:0]  bitn;
  logic [3:0]  bitn_nxt;
  logic [7:0]  shreg;
  logic        par;
  logic [19:0] lim;
  logic        waiting;
  logic        evt;
  logic        tmo_arm;
  logic        tmo_fire;
  logic        accept;

  // A send landing on the done/err pulse cycle is dropped, not queued.
  assign accept   = (state == IDLE) && send && !done && !err;
  assign waiting  = (state == RELEASE) || (state == SEND) ||
                    (state == ACK) || (state == WAIT_IDLE);
  assign lim      = (state == RELEASE) ? FIRST_LIM : EDGE_LIM;
  assign evt      = (state == WAIT_IDLE) ? (clk_s & data_s) : clk_fall;
  assign bitn_nxt = bitn + 4'd1;

  // Lines are released one cycle ahead of the err pulse so err always sees them free.
  assign tmo_arm  = waiting && (cnt == lim - 20'd2);
  assign tmo_fire = waiting && (cnt == lim - 20'd1);

  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= data;
      par   <= odd_parity(data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bitn        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            cnt         <= '0;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            ps2_data_oe <= 1'b1;
            state       <= REQ;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        REQ: begin
          ps2_clk_oe <= 1'b0;
          bitn       <= '0;
          cnt        <= '0;
          state      <= RELEASE;
        end
        RELEASE, SEND, ACK, WAIT_IDLE: begin
          if (tmo_fire) begin
            err         <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= IDLE;
          end else if (evt) begin
            cnt <= '0;
            case (state)
              RELEASE: begin
                ps2_data_oe <= ~shreg[0];
                bitn        <= 4'd1;
                state       <= SEND;
              end
              SEND: begin
                bitn <= bitn_nxt;
                if (bitn_nxt == BIT_PARITY) begin
                  ps2_data_oe <= ~par;
                end else if (bitn_nxt == BIT_STOP) begin
                  ps2_data_oe <= 1'b0;
                  state       <= ACK;
                end else begin
                  ps2_data_oe <= ~shreg[bitn[2:0]];
                end
              end
              ACK: begin
                bitn <= BIT_ACK;
                if (!data_s) begin
                  state <= WAIT_IDLE;
                end else begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end
              default: begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            endcase
          end else begin
            if (tmo_arm) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
            end
            cnt <= (cnt == lim) ? cnt : cnt + 20'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It drives the bidirectional PS/2 lines through open-drain enables and shares the ps2_clk/ps2_data pins with the existing PS/2 scan-code receiver. While busy is high the receiver must ignore the lines; the top level gates the receiver's sampling with busy.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request-to-send (100 us at 50 MHz).
FIRST_TIMEOUT, 750000, max clk cycles from clock release to the first device falling edge (15 ms at 50 MHz).
EDGE_TIMEOUT, 100000, max clk cycles between consecutive device falling edges (2 ms at 50 MHz).

Ports:
clk  in  1  system clock; sole clock domain.
rst  in  1  synchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock pin level (asynchronous).
ps2_data  in  1  raw PS/2 data pin level (asynchronous).
ps2_clk_oe  out  1  1 = pull the PS/2 clock line low; 0 = release it.
ps2_data_oe  out  1  1 = pull the PS/2 data line low; 0 = release it.
data  in  8  command byte; sampled on the accepted send.
send  in  1  request strobe; ignored while busy=1.
busy  out  1  high from the cycle after send is accepted until done or err.
done  out  1  one-cycle pulse: byte sent and device ACK (data=0) sampled.
err  out  1  one-cycle pulse: NACK or timeout; lines already released.

Behaviour:
- Reset: while rst=1, all outputs are 0, state=IDLE, counters cleared. Reset mid-transfer releases both lines in the very next cycle.
- Input synchronizer: 3-flop shift per pin, same scheme as the receiver.
  - fall = sync[2] & ~sync[1]. Data is sampled from the synchronized copy.
- IDLE: outputs low. On send=1, latch data into shreg and compute par = ~^data (odd parity).
  - Next cycle: busy=1, ps2_clk_oe=1, state -> INHIBIT, cnt=0.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0, for INHIBIT_CYCLES cycles.
  - Then state -> REQ: ps2_data_oe=1 (start bit 0) with ps2_clk_oe still 1, for exactly 1 cycle.
- RELEASE: ps2_clk_oe=0, ps2_data_oe=1, bitn=0, timer=0. Wait for fall; timeout limit is FIRST_TIMEOUT.
- SEND: each fall increments bitn and sets the data line. Timer resets on each fall; limit EDGE_TIMEOUT.
  - Falls 1..8: ps2_data_oe = ~shreg[bitn-1], LSB first.
  - Fall 9: ps2_data_oe = ~par.
  - Fall 10: ps2_data_oe=0 (stop bit 1, line released) -> ACK.
- ACK: on fall 11, sample synchronized ps2_data.
  - 0 -> WAIT_IDLE.
  - 1 -> err pulse, busy=0, IDLE.
- WAIT_IDLE: wait until synced ps2_clk=1 and ps2_data=1 (device released ACK).
  - Then done=1 for 1 cycle, busy=0, IDLE. Limit EDGE_TIMEOUT.
- Timeout in any waiting state: same cycle ps2_clk_oe=0 and ps2_data_oe=0; next cycle err=1, busy=0, IDLE.
- done and err are mutually exclusive and never asserted while busy=1.
  - busy falls in the same cycle as the done/err pulse.
- send during busy: dropped, no queueing. send in the same cycle as the done/err pulse: dropped.
  - send is accepted only when state=IDLE.
- Counters: cnt/timer is 20 bits and saturates at its limit; never wraps.
  - bitn is 4 bits, range 0..11.
- Device pulling clock low while IDLE (normal keyboard traffic) has no effect on this block.

Decomposition:
- Package ps2_pkg holds:
  - state enum IDLE, INHIBIT, REQ, RELEASE, SEND, ACK, WAIT_IDLE;
  - constants BIT_PARITY=9, BIT_STOP=10, BIT_ACK=11;
  - odd_parity(byte) function.
- Sub-module ps2_sync_fall (3-flop synchronizer plus falling-edge detect). Also reusable by the receiver; instantiate one per pin.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz:
  - ps2_clk_oe high exactly INHIBIT_CYCLES+1 cycles, data_oe rises one cycle before clk_oe falls;
  - line bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - device ACK 0 -> done pulse once, busy 0.
- Send 0xF4 (parity 0) and 0x00 (parity 1): device-side decode matches the byte and parity bit each time; done asserted.
- Device drives ACK=1 (NACK): err=1 for one cycle, done never asserted, both oe=0.
- Device never clocks: err exactly FIRST_TIMEOUT cycles after clock release, oe lines 0.
  - Device stops after 5 edges: err after EDGE_TIMEOUT.
- send pulsed at every cycle while busy: exactly one transfer, one done. Back-to-back 0xED then 0x07: two correct frames.
- rst asserted during SEND at bit 4: next cycle ps2_clk_oe=ps2_data_oe=busy=0, no done/err; a subsequent send of 0xFF completes normally.
